// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with first-word-fall-through read data,
// occupancy count, almost-full/empty thresholds, sticky error flags and flush.
module fifo_param #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEPTH           = 16,
   parameter int unsigned AF_THRESH       = 14,
   parameter int unsigned AE_THRESH       = 1,
   parameter bit          BLOCK_RD_ON_OVF = 1'b0,
   localparam int unsigned ADDR_W         = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              wr_request,
   output logic [WIDTH-1:0]  rd_data,
   input  logic              rd_request,
   input  logic              flush,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clear_overflow_request,
   input  logic              clear_underflow_request,
   output logic [ADDR_W-1:0] wr_index,
   output logic [ADDR_W-1:0] rd_index
);

   localparam logic [ADDR_W:0] AfThresh = (ADDR_W + 1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AeThresh = (ADDR_W + 1)'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];

   // One extra pointer bit distinguishes full from empty so all entries are usable.
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic            overflow_q, overflow_d;
   logic            underflow_q, underflow_d;

   logic rd_blocked;
   logic wr_accept, rd_accept;
   logic wr_error, rd_error;

   // Status derives only from registered pointers, so requests never feed flags.
   assign wr_index     = wr_ptr_q[ADDR_W-1:0];
   assign rd_index     = rd_ptr_q[ADDR_W-1:0];
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) && (wr_index == rd_index);
   assign count        = wr_ptr_q - rd_ptr_q;
   assign almost_empty = (count <= AeThresh);
   assign almost_full  = (count >= AfThresh);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign rd_data      = mem[rd_index];

   // Accept/error decode and next-state for pointers and sticky flags.
   always_comb begin
      rd_blocked  = BLOCK_RD_ON_OVF && overflow_q;
      wr_accept   = wr_request && !full && !flush;
      rd_accept   = rd_request && !empty && !rd_blocked && !flush;
      wr_error    = wr_request && full && !flush;
      rd_error    = rd_request && (empty || rd_blocked) && !flush;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
      end

      // A new error in the same cycle as its clear keeps the flag set.
      if (clear_overflow_request)  overflow_d  = 1'b0;
      if (wr_error)                overflow_d  = 1'b1;
      if (clear_underflow_request) underflow_d = 1'b0;
      if (rd_error)                underflow_d = 1'b1;
   end

   // Pointer and flag registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array; contents are not reset.
   always_ff @(posedge clk) begin
      if (reset && wr_accept) mem[wr_index] <= wr_data;
   end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: default instance plus a small blocking-mode instance.
module tb_fifo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Default instance (WIDTH=8, DEPTH=16, AF=14, AE=1).
   logic       reset, wr_request, rd_request, flush, clr_o, clr_u;
   logic [7:0] wr_data, rd_data;
   logic       empty, full, almost_empty, almost_full, overflow, underflow;
   logic [4:0] count;
   logic [3:0] wr_index, rd_index;

   fifo_param dut (
      .clk(clk), .reset(reset), .wr_data(wr_data), .wr_request(wr_request),
      .rd_data(rd_data), .rd_request(rd_request), .flush(flush), .empty(empty),
      .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
      .count(count), .overflow(overflow), .underflow(underflow),
      .clear_overflow_request(clr_o), .clear_underflow_request(clr_u),
      .wr_index(wr_index), .rd_index(rd_index)
   );

   // Blocking-mode instance (WIDTH=12, DEPTH=4).
   logic        reset2, wr2, rd2, flush2, clr_o2, clr_u2;
   logic [11:0] wd2, rdd2;
   logic        empty2, full2, ae2, af2, ovf2, unf2;
   logic [2:0]  count2;
   logic [1:0]  wi2, ri2;

   fifo_param #(
      .WIDTH(12), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .BLOCK_RD_ON_OVF(1'b1)
   ) dut2 (
      .clk(clk), .reset(reset2), .wr_data(wd2), .wr_request(wr2),
      .rd_data(rdd2), .rd_request(rd2), .flush(flush2), .empty(empty2),
      .full(full2), .almost_empty(ae2), .almost_full(af2),
      .count(count2), .overflow(ovf2), .underflow(unf2),
      .clear_overflow_request(clr_o2), .clear_underflow_request(clr_u2),
      .wr_index(wi2), .rd_index(ri2)
   );

   typedef struct {
      logic       wr;
      logic [7:0] wd;
      logic       rd;
      logic       co;
      logic       cu;
      logic       chk_rd;
      logic [7:0] head;
      logic [4:0] cnt;
      logic       emp;
      logic       ful;
      logic       ae;
      logic       af;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic status(input string tag, input int cnt, input logic emp, input logic ful,
                         input logic ae, input logic af, input logic ovf, input logic unf);
      chk({tag, " count"}, 32'(count), 32'(cnt));
      chk({tag, " empty"}, 32'(empty), 32'(emp));
      chk({tag, " full"}, 32'(full), 32'(ful));
      chk({tag, " almost_empty"}, 32'(almost_empty), 32'(ae));
      chk({tag, " almost_full"}, 32'(almost_full), 32'(af));
      chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
      chk({tag, " underflow"}, 32'(underflow), 32'(unf));
   endtask

   task automatic idle1();
      wr_request = 1'b0; rd_request = 1'b0; flush = 1'b0; clr_o = 1'b0; clr_u = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic rd,
                               input logic co, input logic cu, input logic chk_rd,
                               input logic [7:0] head, input int cnt, input logic ovf,
                               input logic unf);
      vec_t v;
      v.wr = wr; v.wd = wd; v.rd = rd; v.co = co; v.cu = cu;
      v.chk_rd = chk_rd; v.head = head; v.cnt = 5'(cnt);
      v.emp = (cnt == 0); v.ful = (cnt == 16);
      v.ae = (cnt <= 1); v.af = (cnt >= 14);
      v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   initial begin
      reset = 1'b0; wr_data = '0; idle1();
      reset2 = 1'b0; wd2 = '0; wr2 = 1'b0; rd2 = 1'b0; flush2 = 1'b0;
      clr_o2 = 1'b0; clr_u2 = 1'b0;

      // Fill 16, overflow write, drain 16 in order, underflow read, clear both.
      for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 8'(i), 0, 0, 0, 0, 0, i + 1, 0, 0));
      vecs.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 0, 16, 1, 0));
      for (int j = 0; j < 16; j++) vecs.push_back(mk(0, 0, 1, 0, 0, 1, 8'(j), 15 - j, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));

      // Reset state.
      tick(); tick();
      reset = 1'b1;
      status("reset", 0, 1, 0, 1, 0, 0, 0);
      chk("reset wr_index", 32'(wr_index), 32'd0);
      chk("reset rd_index", 32'(rd_index), 32'd0);

      foreach (vecs[k]) begin
         wr_request = vecs[k].wr; wr_data = vecs[k].wd; rd_request = vecs[k].rd;
         clr_o = vecs[k].co; clr_u = vecs[k].cu;
         if (vecs[k].chk_rd) chk($sformatf("v%0d head", k), 32'(rd_data), 32'(vecs[k].head));
         tick();
         idle1();
         status($sformatf("v%0d", k), int'(vecs[k].cnt), vecs[k].emp, vecs[k].ful,
                vecs[k].ae, vecs[k].af, vecs[k].ovf, vecs[k].unf);
      end

      // Streaming: fill 8, then 40 cycles of simultaneous write/read.
      for (int i = 0; i < 8; i++) begin
         wr_request = 1'b1; wr_data = 8'(i); tick();
      end
      idle1();
      status("fill8", 8, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 40; k++) begin
         wr_request = 1'b1; rd_request = 1'b1; wr_data = 8'(8 + k);
         chk($sformatf("stream%0d head", k), 32'(rd_data), 32'(k));
         tick();
         idle1();
         chk($sformatf("stream%0d count", k), 32'(count), 32'd8);
         chk($sformatf("stream%0d flags", k), {30'd0, overflow, underflow}, 32'd0);
      end
      // 64 writes and 56 reads since reset.
      chk("stream wr_index", 32'(wr_index), 32'd0);
      chk("stream rd_index", 32'(rd_index), 32'd8);

      // Flush at count 5 with both strobes high.
      for (int i = 0; i < 3; i++) begin
         rd_request = 1'b1; tick();
      end
      idle1();
      chk("pre-flush count", 32'(count), 32'd5);
      flush = 1'b1; wr_request = 1'b1; rd_request = 1'b1; wr_data = 8'h77;
      tick();
      idle1();
      status("flush", 0, 1, 0, 1, 0, 0, 0);
      chk("flush wr_index", 32'(wr_index), 32'd0);
      chk("flush rd_index", 32'(rd_index), 32'd0);

      // Mid-stream reset at count 9, with a write pending in the same cycle.
      for (int i = 0; i < 9; i++) begin
         wr_request = 1'b1; wr_data = 8'(i); tick();
      end
      idle1();
      chk("pre-reset count", 32'(count), 32'd9);
      reset = 1'b0; wr_request = 1'b1;
      tick();
      reset = 1'b1; idle1();
      status("midreset", 0, 1, 0, 1, 0, 0, 0);

      // Simultaneous write/read while empty: write taken, read rejected.
      wr_request = 1'b1; rd_request = 1'b1; wr_data = 8'h5C;
      tick();
      idle1();
      status("wr+rd empty", 1, 0, 0, 1, 0, 0, 1);
      chk("wr+rd empty head", 32'(rd_data), 32'h5C);

      // Set-wins-over-clear on underflow: read while empty alongside its clear.
      rd_request = 1'b1; tick(); idle1();
      clr_u = 1'b1; rd_request = 1'b1;
      tick();
      idle1();
      chk("set-wins underflow", 32'(underflow), 32'd1);
      clr_u = 1'b1; tick(); idle1();
      chk("underflow cleared", 32'(underflow), 32'd0);

      // Write while full with a read in the same cycle: write dropped, read taken.
      for (int i = 0; i < 16; i++) begin
         wr_request = 1'b1; wr_data = 8'(8'h40 + i); tick();
      end
      idle1();
      chk("refill full", 32'(full), 32'd1);
      wr_request = 1'b1; rd_request = 1'b1; wr_data = 8'hEE;
      tick();
      idle1();
      status("full wr+rd", 15, 0, 0, 0, 1, 1, 0);
      chk("full wr+rd head", 32'(rd_data), 32'h41);

      // Blocking-mode instance: overflow blocks reads until cleared.
      tick(); reset2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr2 = 1'b1; wd2 = (i == 0) ? 12'hABC : 12'(i); tick();
      end
      wr2 = 1'b0;
      chk("b full", 32'(full2), 32'd1);
      chk("b count4", 32'(count2), 32'd4);
      wr2 = 1'b1; wd2 = 12'h555; tick(); wr2 = 1'b0;
      chk("b overflow", 32'(ovf2), 32'd1);
      chk("b count ovf", 32'(count2), 32'd4);
      rd2 = 1'b1; tick(); rd2 = 1'b0;
      chk("b blocked count", 32'(count2), 32'd4);
      chk("b blocked underflow", 32'(unf2), 32'd1);
      clr_o2 = 1'b1; tick(); clr_o2 = 1'b0;
      chk("b overflow cleared", 32'(ovf2), 32'd0);
      chk("b head", 32'(rdd2), 32'hABC);
      rd2 = 1'b1; tick(); rd2 = 1'b0;
      chk("b read count", 32'(count2), 32'd3);
      chk("b next head", 32'(rdd2), 32'h001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous single-clock FIFO; successor to the 8x15 FIFO used between the I2C register interface and the I2C FSM. It adds configurable width and depth, full usable depth via an extra pointer bit, and an occupancy count. It also provides almost-full/almost-empty thresholds, sticky underflow alongside sticky overflow, a synchronous flush, and an optional read-block-on-overflow mode. The same block instantiates as TX and RX buffers of the I2C peripheral.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2; all DEPTH entries usable
AF_THRESH, 14, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
BLOCK_RD_ON_OVF, 0, 1 = reads rejected while overflow is set
(derived localparam ADDR_W = clog2(DEPTH))

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
wr_data  in  WIDTH  write data
wr_request  in  1  write strobe, one entry per cycle high
rd_data  out  WIDTH  first-word-fall-through head data
rd_request  in  1  pop strobe, one entry per cycle high
flush  in  1  synchronous empty of contents
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_THRESH
almost_full  out  1  count >= AF_THRESH
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty (or blocked)
clear_overflow_request  in  1  clears overflow
clear_underflow_request  in  1  clears underflow
wr_index  out  ADDR_W  write address (pointer LSBs)
rd_index  out  ADDR_W  read address (pointer LSBs)

Behaviour:
- Pointers wr_ptr and rd_ptr are ADDR_W+1 bits. Index outputs are their low ADDR_W bits.
- empty: pointers equal. full: MSBs differ, LSBs equal. count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- Reset (reset==0 at clk edge): pointers, count, overflow and underflow go to 0. Outputs are then empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0). Memory contents are not reset.
- A reset asserted mid-operation discards all entries in that cycle. reset has priority over every other input.
- Write accept = wr_request & ~full. On accept, mem[wr_index] <= wr_data and wr_ptr increments; the pointer wraps naturally at 2^(ADDR_W+1).
- Write while full: data dropped, pointer unchanged, overflow <= 1. This holds even if a read is accepted in the same cycle, since full is evaluated on the pre-edge state.
- Read accept = rd_request & ~empty & ~(BLOCK_RD_ON_OVF & overflow). On accept, rd_ptr increments.
- Read request not accepted: underflow <= 1 and rd_ptr is unchanged.
- Simultaneous write and read:
  - Neither full nor empty: both are accepted and count is unchanged.
  - When empty: the write is accepted, the read is rejected and underflow is set.
- rd_data = mem[rd_index], combinational (FWFT). It is valid whenever empty==0 and changes the cycle after a read is accepted. The value while empty is unspecified.
- Status outputs (flags, count, indices) derive combinationally from registered pointers. They update the cycle after the accepting edge, giving 1-cycle write-to-not-empty latency.
- Sticky flags: a clear request drops the flag at the next edge. If a new error event occurs in the same cycle as its clear, set wins.
- flush (reset high): rd_ptr <= wr_ptr, emptying the FIFO in one cycle.
  - wr_request and rd_request in the same cycle are ignored and raise no flags.
  - overflow and underflow are untouched by flush.
- No combinational path from rd_request to full or from wr_request to empty.

Test Plan:
1. reset low 2 cycles, then high -> empty=1, full=0, count=0, almost_empty=1, overflow=0, underflow=0, wr_index=rd_index=0.
2. Write 16 bytes 0x00..0x0F (defaults) -> almost_full=1 at count 14, full=1 at count 16. A 17th write (0xAA) sets overflow=1, count stays 16, and 0xAA is never read back.
3. Read 16 times -> rd_data sequence 0x00..0x0F. A 17th read sets underflow=1 with count=0. Both clear requests return the flags to 0 on the next edge.
4. Fill to 8, then 40 cycles of simultaneous write and read with incrementing data -> count stays 8, in-order data, pointers wrap past index 15 to 0, no flags set.
5. Count=5 with flush, wr_request and rd_request high together -> next cycle count=0, empty=1, flags unchanged. reset low mid-stream with count=9 -> count=0 next cycle.
6. BLOCK_RD_ON_OVF=1, WIDTH=12, DEPTH=4: fill to 4 and write again (overflow=1); rd_request is then rejected (count stays 4, underflow=1). clear_overflow_request -> next read returns the first written word (0xABC).
